// File: rtl/clk_edge_strobe_pkg.sv
// ---------------------------------------------------------------------------
// clk_edge_strobe_pkg
//   Shared definitions for the clock-edge strobe receiver and its
//   synchroniser: FSM state encoding, glitch counter width and the legal
//   range of synchroniser depth.
// ---------------------------------------------------------------------------
package clk_edge_strobe_pkg;

    // Two-bit state encoding for the debounce FSM
    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE_LOW  = ST_IDLE_LOW,
        WAIT_HIGH = ST_WAIT_HIGH,
        IDLE_HIGH = ST_IDLE_HIGH,
        WAIT_LOW  = ST_WAIT_LOW
    } edge_state_t;

    // Glitch counter width and its saturation value
    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

    // Legal synchroniser depth
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Saturating increment for the glitch counter
    function automatic logic [GLITCH_W-1:0] glitch_inc(input logic [GLITCH_W-1:0] c);
        return (c == GLITCH_MAX) ? c : c + GLITCH_ONE;
    endfunction

endpackage

// File: rtl/clk_edge_strobe_sync.sv
// ---------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchroniser for a single asynchronous level.
//   Ports:
//     clk  - destination clock
//     rst  - synchronous active-high reset, clears every stage to 0
//     d    - asynchronous input level
//     q    - synchronised level (last stage)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Plain shift chain; stage 0 is the one that may go metastable
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_edge_strobe.sv
// ---------------------------------------------------------------------------
// clk_edge_strobe
//   Receives a slow or asynchronous clock-like level, synchronises and
//   debounces it, and produces single-cycle rise/fall clock enables in the
//   clk domain. Also measures the rise-to-rise period and counts rejected
//   glitches.
//   Ports:
//     clk          - system clock, all logic on rising edge
//     rst          - synchronous active-high reset
//     in_raw       - asynchronous / slow input level
//     level        - debounced accepted level
//     rise         - one-cycle strobe on an accepted 0->1
//     fall         - one-cycle strobe on an accepted 1->0
//     period       - clk cycles between the last two rise strobes
//     period_valid - one-cycle strobe when period updates
//     glitch_cnt   - aborted debounce attempts, saturating at 255
// ---------------------------------------------------------------------------
module clk_edge_strobe
    import clk_edge_strobe_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_raw,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    // Out-of-range depths are clamped rather than producing a broken chain
    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            SYNC_STAGES;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    logic s;

    edge_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic accept_rise;
    logic accept_fall;
    logic glitch_hit;

    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] pcnt_inc;
    logic                seen_first;

    sync_ff #(
        .STAGES(SYNC_N)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_raw),
        .q   (s)
    );

    // State register: FSM state and debounce down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: the counter is loaded on entry to a WAIT state and
    // the new level is accepted once it reads zero with the level still held
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                end else if (cnt == '0) begin
                    state_next = IDLE_HIGH;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                end else if (cnt == '0) begin
                    state_next = IDLE_LOW;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
            end
        endcase
    end

    // Output decode: these are the events that get registered onto the ports
    always_comb begin
        accept_rise = (state == WAIT_HIGH) && s && (cnt == '0);
        accept_fall = (state == WAIT_LOW) && !s && (cnt == '0);
        glitch_hit  = ((state == WAIT_HIGH) && !s) || ((state == WAIT_LOW) && s);
    end

    // Registered strobes, accepted level and glitch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            rise <= accept_rise;
            fall <= accept_fall;
            if (accept_rise) begin
                level <= 1'b1;
            end else if (accept_fall) begin
                level <= 1'b0;
            end
            if (glitch_hit) begin
                glitch_cnt <= glitch_inc(glitch_cnt);
            end
        end
    end

    assign pcnt_inc = (pcnt == PERIOD_MAX) ? PERIOD_MAX : pcnt + PERIOD_ONE;

    // Period measurement: the counter restarts on every accepted rise; the
    // very first rise only arms the measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            seen_first   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (accept_rise) begin
                if (seen_first) begin
                    period       <= pcnt_inc;
                    period_valid <= 1'b1;
                end
                pcnt       <= '0;
                seen_first <= 1'b1;
            end else begin
                pcnt <= pcnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_clk_edge_strobe.sv
// ---------------------------------------------------------------------------
// tb_clk_edge_strobe
//   Scoreboard bench: stimulus pushes expected strobe events, a monitor pops
//   and compares them whenever either DUT presents a strobe. A second DUT
//   with a 4-bit period shares the same input to exercise saturation.
// ---------------------------------------------------------------------------
module tb_clk_edge_strobe;
    import clk_edge_strobe_pkg::*;

    // Edges from in_raw change to strobe: 2 sync + 4 debounce + 1 register
    localparam int LAT = 7;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;

    typedef struct {
        int kind;
        int cyc;
        bit pv;
        int period;
        int period4;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        in_raw;
    logic        level, rise, fall, period_valid;
    logic [15:0] period;
    logic [7:0]  glitch_cnt;
    logic        level4, rise4, fall4, period_valid4;
    logic [3:0]  period4;
    logic [7:0]  glitch_cnt4;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    ev_t sb[$];

    bit  m_seen_first = 0;
    int  m_last_rise = 0;

    clk_edge_strobe dut (
        .clk          (clk),
        .rst          (rst),
        .in_raw       (in_raw),
        .level        (level),
        .rise         (rise),
        .fall         (fall),
        .period       (period),
        .period_valid (period_valid),
        .glitch_cnt   (glitch_cnt)
    );

    clk_edge_strobe #(
        .PERIOD_W(4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .in_raw       (in_raw),
        .level        (level4),
        .rise         (rise4),
        .fall         (fall4),
        .period       (period4),
        .period_valid (period_valid4),
        .glitch_cnt   (glitch_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue an expected strobe; rise events carry the modelled period
    task automatic pushEvent(input int kind, input int at_cyc);
        ev_t e;
        int  diff;
        e.kind = kind;
        e.cyc = at_cyc;
        e.pv = 0;
        e.period = 0;
        e.period4 = 0;
        if (kind == K_RISE) begin
            if (m_seen_first) begin
                diff = at_cyc - m_last_rise;
                e.pv = 1;
                e.period = (diff > 65535) ? 65535 : diff;
                e.period4 = (diff > 15) ? 15 : diff;
            end
            m_seen_first = 1;
            m_last_rise = at_cyc;
        end
        sb.push_back(e);
    endtask

    // Drive in_raw for hold cycles; optionally expect the accepted strobe
    task automatic applyStimulus(input bit v, input int hold, input bit want_strobe);
        @(negedge clk);
        in_raw = v;
        if (want_strobe) pushEvent(v ? K_RISE : K_FALL, cyc + LAT);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic doReset(input bit v);
        @(negedge clk);
        rst = 1'b1;
        in_raw = v;
        repeat (3) @(negedge clk);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_rise", rise, 0);
        checkOutput("reset_fall", fall, 0);
        checkOutput("reset_period_valid", period_valid, 0);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_glitch_cnt", glitch_cnt, 0);
        checkOutput("reset_period4", period4, 0);
        m_seen_first = 0;
        rst = 1'b0;
    endtask

    // Monitor: every strobe on either DUT must match the head of the queue
    initial begin
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            if (rise && fall) checkOutput("rise_fall_exclusive", 1, 0);
            if (rise || fall || period_valid || rise4 || fall4 || period_valid4) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe_cycle", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    kind = rise ? K_RISE : (fall ? K_FALL : 0);
                    checkOutput("strobe_kind", kind, e.kind);
                    checkOutput("strobe_cycle", cyc, e.cyc);
                    checkOutput("strobe_level", level, (e.kind == K_RISE) ? 1 : 0);
                    checkOutput("period_valid", period_valid, e.pv);
                    checkOutput("period_valid4", period_valid4, e.pv);
                    checkOutput("dut4_rise", rise4, (e.kind == K_RISE) ? 1 : 0);
                    checkOutput("dut4_fall", fall4, (e.kind == K_FALL) ? 1 : 0);
                    if (e.pv) begin
                        checkOutput("period", period, e.period);
                        checkOutput("period4", period4, e.period4);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain;
        rst = 1'b1;
        in_raw = 1'b1;

        // Reset held with input high, then a rise after normal latency
        $display("[TB] reset with input high");
        repeat (3) @(negedge clk);
        checkOutput("rst_hold_level", level, 0);
        checkOutput("rst_hold_rise", rise, 0);
        checkOutput("rst_hold_glitch", glitch_cnt, 0);
        rst = 1'b0;
        pushEvent(K_RISE, cyc + LAT);
        repeat (19) @(negedge clk);
        checkOutput("level_after_release", level, 1);
        applyStimulus(1'b0, 20, 1'b1);
        checkOutput("level_after_fall", level, 0);

        // 20-cycle square wave
        $display("[TB] square wave");
        doReset(1'b0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 10, 1'b1);
            applyStimulus(1'b0, 10, 1'b1);
        end
        repeat (10) @(negedge clk);

        // Short pulses are rejected and counted
        $display("[TB] glitches");
        doReset(1'b0);
        applyStimulus(1'b1, 3, 1'b0);
        applyStimulus(1'b0, 10, 1'b0);
        checkOutput("glitch_one", glitch_cnt, 1);
        checkOutput("glitch_one_level", level, 0);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(1'b1, 3, 1'b0);
            applyStimulus(1'b0, 3, 1'b0);
        end
        repeat (10) @(negedge clk);
        checkOutput("glitch_saturated", glitch_cnt, 255);
        checkOutput("glitch_saturated4", glitch_cnt4, 255);
        checkOutput("glitch_saturated_level", level, 0);

        // Boundary pulse widths: 5 accepted, 4 rejected
        $display("[TB] boundary pulses");
        doReset(1'b0);
        applyStimulus(1'b1, 5, 1'b1);
        applyStimulus(1'b0, 20, 1'b1);
        checkOutput("pulse5_glitch", glitch_cnt, 0);
        applyStimulus(1'b1, 4, 1'b0);
        applyStimulus(1'b0, 20, 1'b0);
        checkOutput("pulse4_glitch", glitch_cnt, 1);
        checkOutput("pulse4_level", level, 0);

        // Rises 40 apart: 40 on the wide DUT, saturated 15 on the narrow one
        $display("[TB] period saturation");
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 20, 1'b1);
            applyStimulus(1'b0, 20, 1'b1);
        end
        checkOutput("final_period", period, 40);
        checkOutput("final_period4", period4, 15);

        // Reset during WAIT_HIGH discards the attempt silently
        $display("[TB] reset mid-debounce");
        doReset(1'b0);
        @(negedge clk);
        in_raw = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("mid_state_wait", int'(dut.state), int'(WAIT_HIGH));
        rst = 1'b1;
        in_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_seen_first = 0;
        repeat (20) @(negedge clk);
        checkOutput("mid_glitch", glitch_cnt, 0);
        checkOutput("mid_level", level, 0);
        checkOutput("mid_state_idle", int'(dut.state), int'(IDLE_LOW));

        drain = 0;
        while (sb.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        checkOutput("pending_events", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_edge_strobe.md
Name: clk_edge_strobe

Overview:
- Fast-domain receiver for slow or asynchronous clock-like signals: a divided clock, an external step button, or a slow board clock.
- Synchronises and debounces the input, then emits one-cycle rise and fall strobes as clock enables, so downstream logic stays on the single system clock.
- Also measures the input period in `clk` cycles and counts rejected glitches.
- Sits between board I/O or divider outputs and the processor's step/enable logic.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count; legal values 2..4.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised level must hold before it is accepted; must be >= 1.
- PERIOD_W, 16, width of the period measurement.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_raw  input  1  asynchronous or slow input level.
- level  output  1  debounced, accepted input level.
- rise  output  1  one-cycle strobe on an accepted 0->1 transition.
- fall  output  1  one-cycle strobe on an accepted 1->0 transition.
- period  output  PERIOD_W  clk cycles between the last two rise strobes.
- period_valid  output  1  one-cycle strobe when `period` updates.
- glitch_cnt  output  8  count of aborted debounce attempts; saturates at 255.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - Synchroniser flops = 0; FSM = IDLE_LOW; debounce counter = 0.
  - `level`, `rise`, `fall`, `period_valid` = 0; `period` = 0; `glitch_cnt` = 0.
  - Period counter = 0; `seen_first` flag = 0.
- Synchroniser: SYNC_STAGES-deep shift of `in_raw`; the last stage is `s`. The FSM never reads `in_raw` directly.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - s=1: counter <= DEBOUNCE_CYCLES-1, go to WAIT_HIGH.
  - Otherwise stay.
- WAIT_HIGH:
  - s=0: go to IDLE_LOW, increment `glitch_cnt` (saturating).
  - Else counter==0: go to IDLE_HIGH; `level` <= 1; `rise` <= 1 for exactly one cycle.
  - Else decrement counter.
- IDLE_HIGH and WAIT_LOW: mirror image of the above; accepting a low level sets `level` <= 0 and `fall` <= 1.
- Latency: with `in_raw` stable high from before edge N, `rise` goes high after edge N+SYNC_STAGES+DEBOUNCE_CYCLES and low after the next edge. `fall` has the same latency.
- Minimum accepted pulse: a level held for fewer than DEBOUNCE_CYCLES+1 synchronised cycles is rejected and counted as a glitch.
- Strobe exclusivity: `rise` and `fall` are never high in the same cycle; `level` changes in the same cycle its strobe asserts.
- Period counter:
  - Increments every cycle and saturates at 2^PERIOD_W-1.
  - On the edge asserting `rise`: if `seen_first`=1, `period` <= counter+1 (saturating) and `period_valid` <= 1.
  - Also on that edge, counter <= 0 and `seen_first` <= 1.
  - The first `rise` after reset never asserts `period_valid`.
- Outputs: all outputs are registered; no combinational path from `in_raw`.
- Reset mid-debounce: the in-progress attempt is discarded with no strobe and no glitch count. If `in_raw` is already high at reset release, a `rise` follows after the normal latency.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams);
  - GLITCH_W=8;
  - SYNC_STAGES legal-range constants.
- Sub-module `sync_ff` (parameterised SYNC_STAGES shift, synchronous reset) is natural and reusable for other board inputs.

Test Plan:
1. Reset hold: `rst`=1 for 3 cycles with `in_raw`=1 -> all outputs 0. Release at edge R -> `rise`=1 only after edge R+2+4 (default parameters), `level`=1 thereafter.
2. Square wave, 20-clk period (10 high / 10 low), defaults -> `rise` every 20 cycles and `fall` 10 cycles after each `rise`. First `rise` gives no `period_valid`; every later one gives `period`=20 with `period_valid` pulsed.
3. Glitch: `in_raw` high for 3 cycles, then low -> no `rise`, `glitch_cnt`=1, `level` stays 0. Repeat 300 times -> `glitch_cnt`=255.
4. Boundary pulse: high for exactly 5 synchronised cycles (DEBOUNCE_CYCLES+1) -> accepted, one `rise`. High for 4 -> rejected, `glitch_cnt` increments.
5. Period saturation, PERIOD_W=4: rises 40 cycles apart -> `period`=15.
6. Mid-debounce reset: assert `rst` while in WAIT_HIGH -> no `rise`, `glitch_cnt` unchanged (0), FSM in IDLE_LOW on release.
